// File: rtl/reg_file_param_if.sv
// Register file access bus: one write port, two combinational read ports,
// and the clear-sweep request/busy pair.
interface reg_file_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [WIDTH-1:0]  rdata1;
    logic [ADDR_W-1:0] raddr2;
    logic [WIDTH-1:0]  rdata2;
    logic              clr_req;
    logic              busy;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, clr_req,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, clr_req,
        output rdata1, rdata2, busy
    );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file with two asynchronous read ports, optional
// hard-wired zero entry, optional write-to-read forwarding, and a clear
// sweep that rewrites every entry to PRESET one entry per clock.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | normal operation; user writes accepted, CLR_REQ starts a sweep
// ST_CLEAR | sweep in progress; entry[cnt_q] <= PRESET each edge, BUSY high
module reg_file_param #(
    parameter int               WIDTH    = 32,
    parameter int               ADDR_W   = 5,
    parameter logic [WIDTH-1:0] PRESET   = '0,
    parameter bit               ZERO_REG = 1'b1,
    parameter bit               BYPASS   = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    reg_file_param_if.slave bus
);
    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              sweep_wr;
    logic              user_wr;
    logic              fwd_en;
    logic [WIDTH-1:0]  mem [DEPTH];

    // State and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; user writes only qualify in IDLE, never to a zeroed entry 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_wr = 1'b0;
        user_wr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                user_wr = bus.we && !(ZERO_REG && (bus.waddr == '0));
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                sweep_wr = 1'b1;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage; the sweep has priority but the two never coincide since writes are IDLE-only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PRESET;
            end
        end else if (sweep_wr) begin
            mem[cnt_q] <= PRESET;
        end else if (user_wr) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // Forwarding is gated by reset so a write held during reset is not visible.
    assign fwd_en   = BYPASS && rst_n && user_wr;
    assign bus.busy = (state_q == ST_CLEAR);

    // Read port 1: zero entry first, then forwarded write data, then storage.
    always_comb begin
        bus.rdata1 = mem[bus.raddr1];
        if (ZERO_REG && (bus.raddr1 == '0)) begin
            bus.rdata1 = '0;
        end else if (fwd_en && (bus.waddr == bus.raddr1)) begin
            bus.rdata1 = bus.wdata;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        bus.rdata2 = mem[bus.raddr2];
        if (ZERO_REG && (bus.raddr2 == '0)) begin
            bus.rdata2 = '0;
        end else if (fwd_en && (bus.waddr == bus.raddr2)) begin
            bus.rdata2 = bus.wdata;
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: three instances (default-width without
// bypass, with bypass, and a narrow 8x8 without zero register).
module tb_reg_file_param;
    localparam logic [31:0] PA = 32'hA5A5A5A5;
    localparam logic [7:0]  PC = 8'h3C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    reg_file_param_if #(.WIDTH(32), .ADDR_W(5)) bus_a ();
    reg_file_param_if #(.WIDTH(32), .ADDR_W(5)) bus_b ();
    reg_file_param_if #(.WIDTH(8),  .ADDR_W(3)) bus_c ();

    reg_file_param #(.WIDTH(32), .ADDR_W(5), .PRESET(PA), .ZERO_REG(1'b1), .BYPASS(1'b0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    reg_file_param #(.WIDTH(32), .ADDR_W(5), .PRESET(PA), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    reg_file_param #(.WIDTH(8), .ADDR_W(3), .PRESET(PC), .ZERO_REG(1'b0), .BYPASS(1'b0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic [31:0] ea1;
        logic [31:0] ea2;
        logic [31:0] eb1;
        logic [31:0] eb2;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic [4:0] r1, input logic [4:0] r2, input logic clr);
        bus_a.we = we;  bus_a.waddr = wa; bus_a.wdata = wd;
        bus_a.raddr1 = r1; bus_a.raddr2 = r2; bus_a.clr_req = clr;
        bus_b.we = we;  bus_b.waddr = wa; bus_b.wdata = wd;
        bus_b.raddr1 = r1; bus_b.raddr2 = r2; bus_b.clr_req = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // vector: inputs applied, read ports compared before the edge, then one edge
        vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  5'd0,  PA,           32'h0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h00000005, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd9,  32'h12345678, 5'd9,  5'd0,  PA,           32'h0, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd3,  32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd31, 32'h00000031, 5'd31, 5'd31, PA,           PA,    32'h31,       32'h31};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'h31,       32'h0, 32'h31,       32'h0};

        drive_ab(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0);
        bus_c.we = 1'b0; bus_c.waddr = '0; bus_c.wdata = '0;
        bus_c.raddr1 = '0; bus_c.raddr2 = '0; bus_c.clr_req = 1'b0;

        // reset state, and writes/forwarding ignored while held in reset
        rst_n = 1'b0;
        #23;
        chk("rst_a_rdata1", bus_a.rdata1, PA);
        chk("rst_a_rdata2", bus_a.rdata2, 32'h0);
        chk("rst_a_busy", 32'(bus_a.busy), 32'h0);
        drive_ab(1'b1, 5'd7, 32'h1, 5'd7, 5'd0, 1'b1);
        #10;
        chk("rst_a_write_ignored", bus_a.rdata1, PA);
        chk("rst_b_no_bypass", bus_b.rdata1, PA);
        chk("rst_a_clr_ignored", 32'(bus_a.busy), 32'h0);
        drive_ab(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0);
        rst_n = 1'b1;

        // table: first vector writes on the first edge after reset release
        for (int i = 0; i < 6; i++) begin
            drive_ab(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr1, vecs[i].raddr2, 1'b0);
            #1;
            chk($sformatf("vec%0d_a_rdata1", i), bus_a.rdata1, vecs[i].ea1);
            chk($sformatf("vec%0d_a_rdata2", i), bus_a.rdata2, vecs[i].ea2);
            chk($sformatf("vec%0d_b_rdata1", i), bus_b.rdata1, vecs[i].eb1);
            chk($sformatf("vec%0d_b_rdata2", i), bus_b.rdata2, vecs[i].eb2);
            tick();
        end

        // fill 1..31 with their index, then a one-cycle clear pulse
        for (int a = 1; a < 32; a++) begin
            drive_ab(1'b1, 5'(a), 32'(a), 5'd0, 5'd0, 1'b0);
            tick();
        end
        drive_ab(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
        tick();
        drive_ab(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        n = 0;
        while (bus_a.busy && n < 100) begin
            drive_ab(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
            if (n == 5) begin
                drive_ab(1'b1, 5'd2, 32'hDDDDDDDD, 5'd2, 5'd0, 1'b0);
                #1;
                chk("sweep_a_we_no_fwd", bus_a.rdata1, PA);
                chk("sweep_b_we_no_bypass", bus_b.rdata1, PA);
            end
            if (n == 10) begin
                drive_ab(1'b0, 5'd0, 32'h0, 5'd20, 5'd5, 1'b0);
                #1;
                chk("sweep_a_unswept_20", bus_a.rdata1, 32'd20);
                chk("sweep_a_swept_5", bus_a.rdata2, PA);
                chk("sweep_b_unswept_20", bus_b.rdata1, 32'd20);
            end
            n++;
            tick();
        end
        drive_ab(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        chk("sweep_busy_cycles", 32'(n), 32'd32);
        chk("sweep_b_busy_low", 32'(bus_b.busy), 32'h0);
        for (int a = 0; a < 32; a++) begin
            bus_a.raddr1 = 5'(a);
            #1;
            chk($sformatf("post_sweep_a_entry%0d", a), bus_a.rdata1, (a == 0) ? 32'h0 : PA);
        end

        // write and clear together, clear held high for back-to-back sweeps
        drive_ab(1'b1, 5'd4, 32'h44, 5'd4, 5'd0, 1'b1);
        tick();
        drive_ab(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1);
        #1;
        chk("wr_clr_busy", 32'(bus_a.busy), 32'h1);
        chk("wr_clr_write_done", bus_a.rdata1, 32'h44);
        n = 0;
        while (bus_a.busy && n < 100) begin
            n++;
            tick();
        end
        chk("held_sweep1_cycles", 32'(n), 32'd32);
        chk("held_entry4_cleared", bus_a.rdata1, PA);
        tick();
        chk("held_rearm_busy", 32'(bus_a.busy), 32'h1);
        drive_ab(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0);
        n = 0;
        while (bus_a.busy && n < 100) begin
            n++;
            tick();
        end
        chk("held_sweep2_cycles", 32'(n), 32'd32);

        // asynchronous reset at sweep cycle 12
        drive_ab(1'b1, 5'd30, 32'd30, 5'd30, 5'd0, 1'b0);
        tick();
        drive_ab(1'b0, 5'd0, 32'h0, 5'd30, 5'd0, 1'b1);
        #1;
        chk("pre_rst_entry30", bus_a.rdata1, 32'd30);
        tick();
        bus_a.clr_req = 1'b0;
        bus_b.clr_req = 1'b0;
        n = 0;
        while (bus_a.busy && n < 12) begin
            n++;
            tick();
        end
        chk("mid_rst_reached_cycle12", 32'(n), 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy_async", 32'(bus_a.busy), 32'h0);
        chk("mid_rst_entry30", bus_a.rdata1, PA);
        rst_n = 1'b1;
        drive_ab(1'b1, 5'd6, 32'h66, 5'd6, 5'd0, 1'b0);
        tick();
        chk("post_rst_no_resume", 32'(bus_a.busy), 32'h0);
        chk("post_rst_first_write", bus_a.rdata1, 32'h66);
        drive_ab(1'b0, 5'd0, 32'h0, 5'd6, 5'd0, 1'b0);
        tick();
        chk("post_rst_still_idle", 32'(bus_a.busy), 32'h0);

        // narrow instance without zero register
        bus_c.raddr1 = 3'd0;
        #1;
        chk("c_reset_entry0", 32'(bus_c.rdata1), 32'(PC));
        bus_c.we = 1'b1; bus_c.waddr = 3'd0; bus_c.wdata = 8'hFF;
        tick();
        bus_c.we = 1'b0;
        #1;
        chk("c_entry0_ff", 32'(bus_c.rdata1), 32'hFF);
        bus_c.clr_req = 1'b1;
        tick();
        bus_c.clr_req = 1'b0;
        n = 0;
        while (bus_c.busy && n < 100) begin
            n++;
            tick();
        end
        chk("c_busy_cycles", 32'(n), 32'd8);
        chk("c_entry0_cleared", 32'(bus_c.rdata1), 32'(PC));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
